piso_axi4lite: RTL and testbench



---
 rtl/piso_axi4lite.sv | 243 ++++++++++++++++++++++++
 tb/tb_piso_axi4lite.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_axi4lite.sv
// Parallel-in serial-out transmitter: AXI4-Lite writes fill a FIFO, and each word leaves LSB-first on sout.
// Latency: bit0 appears 2 cycles after the write commits. Backpressure: b/r hold until ready, TXDATA drops when full.
// Optional parity bit after each word is built when PISO_PARITY_EN is defined.
module piso_axi4lite #(
    parameter int AXI4_ADDR_BITS = 32,
    parameter int AXI4_DATA_BITS = 32,
    parameter int AXI4_STRB_BITS = AXI4_DATA_BITS / 8,
    parameter int AXI4_PROT_BITS = 3,
    parameter int AXI4_RESP_BITS = 2,
    parameter int PISO_WIDTH     = 32,
    parameter int PISO_DEPTH     = 16,
    parameter logic [AXI4_ADDR_BITS-1:0] MMIO_BASE_ADDR = 'h1000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      sout,
    output logic                      sout_valid,
    output logic                      s_axi4lite_aw_ready,
    input  logic                      s_axi4lite_aw_valid,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_aw_addr,
    input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_aw_prot,
    output logic                      s_axi4lite_w_ready,
    input  logic                      s_axi4lite_w_valid,
    input  logic [AXI4_DATA_BITS-1:0] s_axi4lite_w_data,
    input  logic [AXI4_STRB_BITS-1:0] s_axi4lite_w_strb,
    input  logic                      s_axi4lite_b_ready,
    output logic                      s_axi4lite_b_valid,
    output logic [AXI4_RESP_BITS-1:0] s_axi4lite_b_resp,
    output logic                      s_axi4lite_ar_ready,
    input  logic                      s_axi4lite_ar_valid,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_ar_addr,
    input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_ar_prot,
    input  logic                      s_axi4lite_r_ready,
    output logic                      s_axi4lite_r_valid,
    output logic [AXI4_DATA_BITS-1:0] s_axi4lite_r_data,
    output logic [AXI4_RESP_BITS-1:0] s_axi4lite_r_resp
);

    localparam int IDX_W = $clog2(PISO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
`ifdef PISO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam logic PAR_FLAG = (PAR_BITS == 1);
    localparam int NBITS = PISO_WIDTH + PAR_BITS;
    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_LEVEL  = 2'd3;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    // AXI write path
    logic                      aw_cap_q, w_cap_q, b_valid_q;
    logic [AXI4_ADDR_BITS-1:0] aw_addr_q;
    logic [AXI4_DATA_BITS-1:0] w_data_q;
    // AXI read path
    logic                      ar_cap_q, r_valid_q;
    logic [AXI4_ADDR_BITS-1:0] ar_addr_q;
    logic [AXI4_DATA_BITS-1:0] r_data_q, rd_mux_d;
    // control, FIFO, serializer
    logic                      enable_q, overflow_q;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q, level;
    logic [PISO_WIDTH-1:0]     mem_q [PISO_DEPTH];
    logic [PISO_WIDTH-1:0]     head;
    logic [NBITS-1:0]          head_ext, shreg_q;
    logic [CNT_W-1:0]          cnt_q;
    state_t                    state_q;
    logic                      sout_q, sout_valid_q;

    logic aw_hs, w_hs, ar_hs, wr_commit, aw_hit, ar_hit;
    logic wr_tx, wr_ctrl, soft_rst;
    logic empty, full, busy, fifo_pop, push_ok;

    assign s_axi4lite_aw_ready = !aw_cap_q && !b_valid_q;
    assign s_axi4lite_w_ready  = !w_cap_q && !b_valid_q;
    assign s_axi4lite_ar_ready = !ar_cap_q && !r_valid_q;
    assign s_axi4lite_b_valid  = b_valid_q;
    assign s_axi4lite_b_resp   = '0;
    assign s_axi4lite_r_valid  = r_valid_q;
    assign s_axi4lite_r_data   = r_data_q;
    assign s_axi4lite_r_resp   = '0;
    assign sout                = sout_q;
    assign sout_valid          = sout_valid_q;

    assign aw_hs = s_axi4lite_aw_valid && s_axi4lite_aw_ready;
    assign w_hs  = s_axi4lite_w_valid && s_axi4lite_w_ready;
    assign ar_hs = s_axi4lite_ar_valid && s_axi4lite_ar_ready;

    assign aw_hit    = aw_addr_q[AXI4_ADDR_BITS-1:4] == MMIO_BASE_ADDR[AXI4_ADDR_BITS-1:4];
    assign ar_hit    = ar_addr_q[AXI4_ADDR_BITS-1:4] == MMIO_BASE_ADDR[AXI4_ADDR_BITS-1:4];
    assign wr_commit = aw_cap_q && w_cap_q && !b_valid_q;
    assign wr_tx     = wr_commit && aw_hit && (aw_addr_q[3:2] == OFF_TXDATA);
    assign wr_ctrl   = wr_commit && aw_hit && (aw_addr_q[3:2] == OFF_CTRL);
    assign soft_rst  = wr_ctrl && w_data_q[1];

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign busy  = state_q != S_IDLE;
    assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

`ifdef PISO_PARITY_EN
    assign head_ext = {^head, head};
`else
    assign head_ext = head;
`endif

    // A pop at the last bit reloads with no idle gap; it also frees the slot for a same-cycle push when full.
    assign fifo_pop = enable_q && !empty && !soft_rst &&
                      ((state_q == S_IDLE) || (cnt_q == CNT_LAST));
    assign push_ok  = wr_tx && (!full || fifo_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            b_valid_q <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_cap_q  <= 1'b1;
                aw_addr_q <= s_axi4lite_aw_addr;
            end
            if (w_hs) begin
                w_cap_q  <= 1'b1;
                w_data_q <= s_axi4lite_w_data;
            end
            if (wr_commit) begin
                aw_cap_q  <= 1'b0;
                w_cap_q   <= 1'b0;
                b_valid_q <= 1'b1;
            end else if (b_valid_q && s_axi4lite_b_ready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux_d = '0;
        if (ar_hit) begin
            case (ar_addr_q[3:2])
                OFF_STATUS: rd_mux_d[5:0] = {PAR_FLAG, overflow_q, enable_q, busy, full, !empty};
                OFF_LEVEL:  rd_mux_d[PTR_W-1:0] = level;
                default:    rd_mux_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_cap_q  <= 1'b0;
            ar_addr_q <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            if (ar_hs) begin
                ar_cap_q  <= 1'b1;
                ar_addr_q <= s_axi4lite_ar_addr;
            end
            if (ar_cap_q) begin
                ar_cap_q  <= 1'b0;
                r_valid_q <= 1'b1;
                r_data_q  <= rd_mux_d;
            end else if (r_valid_q && s_axi4lite_r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else if (wr_ctrl) begin
            enable_q <= w_data_q[0];
            if (w_data_q[1] || w_data_q[2]) begin
                overflow_q <= 1'b0;
            end
        end else if (wr_tx && full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= w_data_q[PISO_WIDTH-1:0];
        end
    end

    // sout_q already holds the bit on the line; shreg_q holds the bits still to come.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
        end else if (fifo_pop) begin
            state_q      <= S_SHIFT;
            cnt_q        <= '0;
            shreg_q      <= head_ext >> 1;
            sout_q       <= head_ext[0];
            sout_valid_q <= 1'b1;
        end else if (state_q == S_SHIFT) begin
            if (cnt_q == CNT_LAST) begin
                state_q      <= S_IDLE;
                sout_q       <= 1'b0;
                sout_valid_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
                shreg_q <= shreg_q >> 1;
                sout_q  <= shreg_q[0];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, s_axi4lite_w_strb,
                         aw_addr_q, ar_addr_q, w_data_q};

endmodule

// File: tb/tb_piso_axi4lite.sv
// Directed bench for piso_axi4lite: register vector table plus hand sequences for serial timing corners.
module tb_piso_axi4lite;

    logic        clk = 1'b0;
    logic        rst;
    logic        sout, sout_valid;
    logic        aw_ready, aw_valid, w_ready, w_valid, b_ready, b_valid;
    logic        ar_ready, ar_valid, r_ready, r_valid;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [2:0]  aw_prot, ar_prot;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    piso_axi4lite dut (
        .clk(clk), .rst(rst), .sout(sout), .sout_valid(sout_valid),
        .s_axi4lite_aw_ready(aw_ready), .s_axi4lite_aw_valid(aw_valid),
        .s_axi4lite_aw_addr(aw_addr), .s_axi4lite_aw_prot(aw_prot),
        .s_axi4lite_w_ready(w_ready), .s_axi4lite_w_valid(w_valid),
        .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb),
        .s_axi4lite_b_ready(b_ready), .s_axi4lite_b_valid(b_valid), .s_axi4lite_b_resp(b_resp),
        .s_axi4lite_ar_ready(ar_ready), .s_axi4lite_ar_valid(ar_valid),
        .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
        .s_axi4lite_r_ready(r_ready), .s_axi4lite_r_valid(r_valid),
        .s_axi4lite_r_data(r_data), .s_axi4lite_r_resp(r_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    bit   bits_q[$];
    int   cyc_q[$];
    int   sout_idle_err = 0;
    int   b_rise = 0;
    logic b_valid_d = 1'b0;

    always @(negedge clk) begin
        if (sout_valid === 1'b1) begin
            bits_q.push_back(sout);
            cyc_q.push_back(cyc);
        end else if (sout !== 1'b0) begin
            sout_idle_err++;
        end
        if (b_valid && !b_valid_d) b_rise++;
        b_valid_d = b_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input int w_lead, output int hs);
        int k;
        bit aw_done, w_done, a, b;
        aw_done = 0; w_done = 0; k = 0; hs = -1;
        aw_addr = addr; w_data = data;
        w_valid = 1'b1;
        aw_valid = (w_lead == 0);
        while (!(aw_done && w_done) && k < 50) begin
            a = aw_valid && aw_ready;
            b = w_valid && w_ready;
            if (a) aw_done = 1;
            if (b) w_done = 1;
            if ((a || b) && aw_done && w_done) hs = cyc;
            @(negedge clk);
            k++;
            if (a) aw_valid = 1'b0;
            if (b) w_valid = 1'b0;
            if (!aw_done && !aw_valid && k >= w_lead) aw_valid = 1'b1;
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("aw_w_handshake", {31'd0, aw_done && w_done}, 32'd1);
        k = 0;
        while (!b_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("b_valid", {31'd0, b_valid}, 32'd1);
        chk("b_resp", {30'd0, b_resp}, 32'd0);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp,
                            input int hold, input string name);
        int k;
        bit a, held;
        ar_addr = addr; ar_valid = 1'b1; k = 0;
        while (ar_valid && k < 50) begin
            a = ar_ready;
            @(negedge clk);
            k++;
            if (a) ar_valid = 1'b0;
        end
        ar_valid = 1'b0;
        k = 0;
        while (!r_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_r_valid"}, {31'd0, r_valid}, 32'd1);
        held = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!r_valid) held = 0;
        end
        if (hold > 0) chk({name, "_r_valid_held"}, {31'd0, held}, 32'd1);
        chk(name, r_data, exp);
        chk({name, "_r_resp"}, {30'd0, r_resp}, 32'd0);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic wait_bits(input int n, input int budget);
        int k;
        k = 0;
        while (bits_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("serial_bits_arrived", {31'd0, bits_q.size() >= n}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [31:0] word_at(input int off);
        logic [31:0] w;
        for (int i = 0; i < 32; i++)
            w[i] = (off + i < bits_q.size()) ? bits_q[off + i] : 1'bx;
        return w;
    endfunction

    function automatic int last_cyc();
        return (cyc_q.size() > 0) ? cyc_q[cyc_q.size() - 1] : -1;
    endfunction

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          rep;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    initial begin
        int hs, n0, b0;
        vecs[0]  = '{0, 32'h1004, 32'h0,    1, 0, 32'h08};
        vecs[1]  = '{0, 32'h100C, 32'h0,    1, 0, 32'h00};
        vecs[2]  = '{0, 32'h1000, 32'h0,    1, 5, 32'h00};
        vecs[3]  = '{0, 32'h1008, 32'h0,    1, 0, 32'h00};
        vecs[4]  = '{0, 32'h2000, 32'h0,    1, 5, 32'h00};
        vecs[5]  = '{1, 32'h1008, 32'h0,    1, 0, 32'h00};
        vecs[6]  = '{1, 32'h2000, 32'hDEAD, 1, 0, 32'h00};
        vecs[7]  = '{0, 32'h1004, 32'h0,    1, 0, 32'h00};
        vecs[8]  = '{1, 32'h1000, 32'h100, 17, 0, 32'h00};
        vecs[9]  = '{0, 32'h100C, 32'h0,    1, 0, 32'h10};
        vecs[10] = '{0, 32'h1004, 32'h0,    1, 0, 32'h13};
        vecs[11] = '{1, 32'h1008, 32'h5,    1, 0, 32'h00};
        vecs[12] = '{0, 32'h1004, 32'h0,    1, 0, 32'h0D};
        vecs[13] = '{0, 32'h100C, 32'h0,    1, 0, 32'h0F};
        vecs[14] = '{0, 32'h1004, 32'h0,    1, 0, 32'h0D};

        rst = 1'b1;
        aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 1; r_ready = 0;
        aw_addr = 0; ar_addr = 0; w_data = 0; aw_prot = 0; ar_prot = 0; w_strb = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_sout", {31'd0, sout}, 32'd0);
        chk("rst_sout_valid", {31'd0, sout_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
        chk("rst_r_data", r_data, 32'd0);
        chk("rst_aw_ready", {31'd0, aw_ready}, 32'd1);
        chk("rst_ar_ready", {31'd0, ar_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single word: bit0 three cycles after the handshake edge cycle, 32 contiguous bits.
        bits_q.delete(); cyc_q.delete();
        axi_write(32'h1000, 32'h0000_00A5, 0, hs);
        wait_bits(32, 100);
        chk("t1_bit_count", bits_q.size(), 32);
        chk("t1_first_cycle", cyc_q[0], hs + 3);
        chk("t1_contiguous", last_cyc() - cyc_q[0], 31);
        chk("t1_word", word_at(0), 32'h0000_00A5);

        // Three back-to-back words, no gaps.
        bits_q.delete(); cyc_q.delete();
        axi_write(32'h1000, 32'h1234_5678, 0, hs);
        axi_write(32'h1000, 32'hFFFF_0000, 0, hs);
        axi_write(32'h1000, 32'h8000_0001, 0, hs);
        wait_bits(96, 200);
        chk("t2_bit_count", bits_q.size(), 96);
        chk("t2_contiguous", last_cyc() - cyc_q[0], 95);
        chk("t2_word0", word_at(0), 32'h1234_5678);
        chk("t2_word1", word_at(32), 32'hFFFF_0000);
        chk("t2_word2", word_at(64), 32'h8000_0001);
        axi_read(32'h100C, 32'h0, 0, "t2_level");
        axi_read(32'h1004, 32'h08, 0, "t2_status");

        // Register table: idle reads, overflow while disabled, resume.
        bits_q.delete(); cyc_q.delete();
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                for (int j = 0; j < vecs[i].rep; j++)
                    axi_write(vecs[i].addr, vecs[i].data + j, 0, hs);
            end else begin
                axi_read(vecs[i].addr, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));
            end
        end
        wait_bits(512, 700);
        chk("t3_bit_count", bits_q.size(), 512);
        chk("t3_contiguous", last_cyc() - cyc_q[0], 511);
        chk("t3_first_word", word_at(0), 32'h100);
        chk("t3_last_word", word_at(480), 32'h10F);
        axi_read(32'h1004, 32'h08, 0, "t3_status_idle");

        // W three cycles ahead of AW, then both together: one push and one response each.
        bits_q.delete(); cyc_q.delete();
        axi_write(32'h1008, 32'h0, 0, hs);
        b0 = b_rise;
        axi_write(32'h1000, 32'h0000_00F0, 3, hs);
        axi_write(32'h1000, 32'h0000_000F, 0, hs);
        chk("t4_b_count", b_rise - b0, 2);
        axi_read(32'h100C, 32'h2, 0, "t4_level");
        axi_write(32'h1008, 32'h1, 0, hs);
        wait_bits(64, 200);
        chk("t4_bit_count", bits_q.size(), 64);
        chk("t4_word0", word_at(0), 32'h0000_00F0);
        chk("t4_word1", word_at(32), 32'h0000_000F);

        // Soft reset while word 2 of 4 is on the line.
        bits_q.delete(); cyc_q.delete();
        axi_write(32'h1000, 32'hDEAD_BEEF, 0, hs);
        axi_write(32'h1000, 32'h0123_4567, 0, hs);
        axi_write(32'h1000, 32'h89AB_CDEF, 0, hs);
        axi_write(32'h1000, 32'h55AA_55AA, 0, hs);
        wait_bits(42, 300);
        axi_write(32'h1008, 32'h3, 0, hs);
        chk("t5_last_valid_cycle", last_cyc(), hs + 1);
        n0 = bits_q.size();
        chk("t5_stopped_in_word2", {31'd0, (n0 > 32) && (n0 < 64)}, 32'd1);
        chk("t5_word0", word_at(0), 32'hDEAD_BEEF);
        axi_read(32'h100C, 32'h0, 0, "t5_level");
        axi_read(32'h1004, 32'h08, 0, "t5_status");
        repeat (40) @(negedge clk);
        chk("t5_no_more_bits", bits_q.size(), n0);

        chk("sout_zero_when_idle", sout_idle_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
